// File: rtl/mux_arb_pkg.sv
// Shared types, constants and round-robin search helper for the 4-input arbiter.
// Used by mux4_rr_arbiter in both the default and ARB_LOCK_EN builds.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic hit;
    sel_t idx;
  } grant_t;

  // Searches ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set request wins.
  function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t ptr);
    grant_t g;
    g = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel_t cand;
      cand = ptr + sel_t'(k);
      if (!g.hit && req[cand]) begin
        g.hit = 1'b1;
        g.idx = cand;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 multiplexer of WIDTH-bit words; sel 0..3 picks d0..d3.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // NOTE: assigning a default before the case keeps this purely combinational (no latch).
  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four valid/ready requesters feeding one registered output stage.
// Define ARB_LOCK_EN to hold the grant on one requester until its in_last word transfers.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic               load_en;
  logic               xfer;
  logic [NUM_REQ-1:0] eligible;
  grant_t             grant;
  sel_t               ptr;
  logic [WIDTH-1:0]   mux_data;

`ifdef ARB_LOCK_EN
  arb_state_t state;
  sel_t       lock_idx;
`else
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  always_comb begin
    eligible = in_valid;
`ifdef ARB_LOCK_EN
    if (state == LOCKED) eligible = in_valid & (NUM_REQ'(1) << lock_idx);
`endif
  end

  assign grant   = rr_pick(eligible, ptr);
  assign load_en = !out_valid || out_ready;

  // Gating with rst_n makes sure nothing is accepted while the stage is being cleared.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant.hit) in_ready[grant.idx] = 1'b1;
  end

  assign xfer = |in_ready;

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .sel (grant.idx),
    .d0  (in_data[0*WIDTH +: WIDTH]),
    .d1  (in_data[1*WIDTH +: WIDTH]),
    .d2  (in_data[2*WIDTH +: WIDTH]),
    .d3  (in_data[3*WIDTH +: WIDTH]),
    .y   (mux_data)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= sel_t'(NUM_REQ - 1);
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        out_src  <= grant.idx;
        ptr      <= grant.idx;
      end
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      lock_idx <= '0;
    end else if (xfer) begin
      if (in_last[grant.idx]) begin
        state <= ARB;
      end else begin
        state    <= LOCKED;
        lock_idx <= grant.idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; expected words go into a scoreboard queue as stimulus is applied.
module tb_mux4_rr_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_last;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic push(input logic [1:0] s, input logic [W-1:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  // One clock: retire the word consumed at this edge, then compare whatever is presented.
  task automatic tick();
    logic consumed;
    consumed = out_valid && out_ready;
    @(posedge clk);
    #1;
    if (consumed && sb.size() > 0) void'(sb.pop_front());
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty observed=word src=%0d data=%0h expected=no word", out_src, out_data);
      end else begin
        check("out_src", 32'(out_src), 32'(sb[0].src));
        check("out_data", 32'(out_data), 32'(sb[0].data));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic x1;

    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < 4; i++) set_data(i, W'(8'h10 + i));

    // Reset state, with requests already pending
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // All requesters valid: rotation 0,1,2,3,0
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    repeat (5) tick();
    in_valid = 4'h0;
    tick();
    check("rr_idle_valid", 32'(out_valid), 32'd0);

    // Single requester 2 with 0xA5
    in_valid = 4'b0100;
    set_data(2, 8'hA5);
    #1;
    check("single_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'hA5);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    in_valid = 4'h0;
    set_data(2, 8'h12);
    tick();

    // Backpressure for three cycles, then resume in RR order
    in_valid = 4'hF;
    #1;
    check("bp_pre_ready", 32'(in_ready), 32'h8);
    push(2'd3, 8'h13);
    tick();
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_stall_ready", 32'(in_ready), 32'h0);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    tick();
    tick();

    // Reset mid-stream
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_src", 32'(out_src), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h10);
    tick();
    in_valid = 4'h0;
    tick();

    // Burst from requester 1 (last on third word) with requester 3 always valid
    cnt      = 0;
    in_valid = 4'b1010;
    set_data(1, 8'h40);
    in_last  = 4'h0;
`ifdef ARB_LOCK_EN
    push(2'd1, 8'h40);
    push(2'd1, 8'h41);
    push(2'd1, 8'h42);
    push(2'd3, 8'h13);
`else
    push(2'd1, 8'h40);
    push(2'd3, 8'h13);
    push(2'd1, 8'h41);
    push(2'd3, 8'h13);
`endif
    #1;
    for (int k = 0; k < 4; k++) begin
      x1 = in_ready[1];
      tick();
      if (x1) cnt++;
      set_data(1, W'(8'h40 + cnt));
      in_last[1] = (cnt == 2);
      #1;
    end
    in_valid = 4'h0;
    in_last  = 4'h0;
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
